// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Field widths are upper bounds; instances zero-extend narrower register and latency fields.
package pipe_hazard_unit_pkg;

    localparam int HZ_REG_MAX = 8;
    localparam int HZ_LAT_MAX = 4;
    localparam int HZ_FWD_MAX = 4;

    typedef struct packed {
        logic                  valid;
        logic [HZ_REG_MAX-1:0] dst;
        logic                  we;
        logic [HZ_LAT_MAX-1:0] lat;
    } hz_slot_t;

    typedef logic [HZ_FWD_MAX-1:0] fwd_sel_t;

    // A latency of zero would mean "result ready before execute"; treat it as ALU latency.
    function automatic logic [HZ_LAT_MAX-1:0] lat_norm(input logic [HZ_LAT_MAX-1:0] lat);
        return (lat == '0) ? HZ_LAT_MAX'(1) : lat;
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand dependency check: finds the youngest in-flight writer of one source
// register and decides between bypass from that slot and a stall.
module hz_src_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_BITS = 5
) (
    input  logic                            src_used,
    input  logic [REG_BITS-1:0]             src,
    input  hz_slot_t                        slots [STAGES],
    output logic                            hazard,
    output logic [$clog2(STAGES+1)-1:0]     fwd_sel
);

    localparam int FSW = $clog2(STAGES + 1);

    fwd_sel_t              match_idx;
    logic [HZ_LAT_MAX-1:0] match_lat;
    logic                  hit;
    logic                  live;

    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        match_lat = '0;
        // Scan oldest to youngest so the youngest writer is the one that sticks.
        for (int k = STAGES; k >= 1; k--) begin
            if (slots[k-1].valid && slots[k-1].we && (slots[k-1].dst != '0) &&
                (slots[k-1].dst == HZ_REG_MAX'(src))) begin
                hit       = 1'b1;
                match_idx = fwd_sel_t'(k);
                match_lat = slots[k-1].lat;
            end
        end
        live    = src_used && (src != '0) && hit;
        hazard  = live && (32'(match_idx) < 32'(match_lat));
        fwd_sel = (live && !hazard) ? FSW'(match_idx) : '0;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller: tracks post-decode instructions in a
// STAGES-deep shift register and drives stall/flush/bypass selects for decode.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int STAGES        = 3,
    parameter int NSRC          = 2,
    parameter int REG_BITS      = 5,
    parameter int LAT_BITS      = 2,
    parameter int REDIRECT_SLOT = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 d_valid,
    input  logic [NSRC*REG_BITS-1:0]             d_src,
    input  logic [NSRC-1:0]                      d_src_used,
    input  logic [REG_BITS-1:0]                  d_dst,
    input  logic                                 d_we,
    input  logic [LAT_BITS-1:0]                  d_lat,
    input  logic                                 ext_stall,
    input  logic                                 redirect,
    output logic                                 stall_fd,
    output logic                                 flush_fd,
    output logic [NSRC*$clog2(STAGES+1)-1:0]     fwd_sel,
    output logic [STAGES-1:0]                    slot_valid,
    output logic [31:0]                          stall_cnt,
    output logic [31:0]                          flush_cnt,
    output logic [31:0]                          retire_cnt
);

    localparam int FSW = $clog2(STAGES + 1);

    // slots[0] is the E slot (slot 1), slots[STAGES-1] is W.
    hz_slot_t        slots [STAGES];
    hz_slot_t        entry;
    logic [NSRC-1:0] src_hazard;
    logic            hazard;
    logic            advance;
    logic            redir;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hz_src_match #(
            .STAGES   (STAGES),
            .REG_BITS (REG_BITS)
        ) u_match (
            .src_used (d_src_used[i]),
            .src      (d_src[i*REG_BITS +: REG_BITS]),
            .slots    (slots),
            .hazard   (src_hazard[i]),
            .fwd_sel  (fwd_sel[i*FSW +: FSW])
        );
    end

    always_comb begin
        hazard   = d_valid & (|src_hazard);
        advance  = ~ext_stall;
        // A redirect raised while the pipe is frozen waits for the next free cycle.
        redir    = redirect & advance;
        flush_fd = redir;
        stall_fd = ext_stall | (hazard & ~redirect);

        entry.valid = d_valid & ~hazard & ~redir;
        entry.dst   = HZ_REG_MAX'(d_dst);
        entry.we    = d_we;
        entry.lat   = lat_norm(HZ_LAT_MAX'(d_lat));

        for (int k = 0; k < STAGES; k++) begin
            slot_valid[k] = slots[k].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                slots[k] <= '0;
            end
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + {31'b0, stall_fd};
            if (advance) begin
                slots[0] <= entry;
                for (int k = 1; k < STAGES; k++) begin
                    slots[k] <= slots[k-1];
                    // Slots younger than the redirecting one are on the wrong path.
                    if (redir && (k < REDIRECT_SLOT)) begin
                        slots[k].valid <= 1'b0;
                    end
                end
                retire_cnt <= retire_cnt + {31'b0, slots[STAGES-1].valid};
                flush_cnt  <= flush_cnt + {31'b0, redir};
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: drives decode/pipe events cycle by cycle and
// checks outputs against a queue of expected values pushed alongside the stimulus.
module tb_pipe_hazard_unit;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [9:0]  d_src;
    logic [1:0]  d_src_used;
    logic [4:0]  d_dst;
    logic        d_we;
    logic [1:0]  d_lat;
    logic        ext_stall;
    logic        redirect;
    logic        stall_fd;
    logic        flush_fd;
    logic [3:0]  fwd_sel;
    logic [2:0]  slot_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] retire_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    int          kind_q [$];
    string       tag_q [$];

    pipe_hazard_unit dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_src      (d_src),
        .d_src_used (d_src_used),
        .d_dst      (d_dst),
        .d_we       (d_we),
        .d_lat      (d_lat),
        .ext_stall  (ext_stall),
        .redirect   (redirect),
        .stall_fd   (stall_fd),
        .flush_fd   (flush_fd),
        .fwd_sel    (fwd_sel),
        .slot_valid (slot_valid),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish within 20000 time units");
        $fatal(1, "bench timeout");
    end

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic we,
                         input logic [1:0] lat, input logic es, input logic rd);
        d_valid    = v;
        d_src      = {s1, s0};
        d_src_used = used;
        d_dst      = dst;
        d_we       = we;
        d_lat      = lat;
        ext_stall  = es;
        redirect   = rd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input int kind, input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        kind_q.push_back(kind);
        tag_q.push_back(tag);
    endtask

    task automatic ex_out(input string tag, input logic [3:0] fwd, input logic st,
                          input logic fl, input logic [2:0] sv);
        push(0, {tag, ".fwd_sel"}, 32'(fwd));
        push(1, {tag, ".stall_fd"}, 32'(st));
        push(2, {tag, ".flush_fd"}, 32'(fl));
        push(3, {tag, ".slot_valid"}, 32'(sv));
    endtask

    task automatic ex_cnt(input string tag, input logic [31:0] s, input logic [31:0] f,
                          input logic [31:0] r);
        push(4, {tag, ".stall_cnt"}, s);
        push(5, {tag, ".flush_cnt"}, f);
        push(6, {tag, ".retire_cnt"}, r);
    endtask

    // Let combinational outputs settle, then drain the expected queue against the DUT.
    task automatic sample();
        logic [31:0] obs;
        logic [31:0] e;
        string       t;
        int          kind;
        #1;
        while (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            kind = kind_q.pop_front();
            t    = tag_q.pop_front();
            case (kind)
                0:       obs = 32'(fwd_sel);
                1:       obs = 32'(stall_fd);
                2:       obs = 32'(flush_fd);
                3:       obs = 32'(slot_valid);
                4:       obs = stall_cnt;
                5:       obs = flush_cnt;
                default: obs = retire_cnt;
            endcase
            n_cmp++;
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        ex_out("reset", 4'b0000, 1'b0, 1'b0, 3'b000);
        ex_cnt("reset", 0, 0, 0);
        sample();

        // ALU chain: add r3<-r1,r2 ; sub r4<-r3,r5 ; user of r3 one cycle later
        @(negedge clk);
        drive(1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 2'd1, 0, 0);
        ex_out("alu_add", 4'b0000, 1'b0, 1'b0, 3'b000);
        sample();
        @(negedge clk);
        drive(1, 5'd3, 5'd5, 2'b11, 5'd4, 1, 2'd1, 0, 0);
        ex_out("alu_sub", 4'b0001, 1'b0, 1'b0, 3'b001);
        sample();
        @(negedge clk);
        drive(1, 5'd6, 5'd3, 2'b11, 5'd7, 1, 2'd1, 0, 0);
        ex_out("alu_use2", 4'b1000, 1'b0, 1'b0, 3'b011);
        sample();
        @(negedge clk);
        idle();
        ex_out("alu_full", 4'b0000, 1'b0, 1'b0, 3'b111);
        ex_cnt("alu_full", 0, 0, 0);
        sample();
        @(negedge clk);
        ex_out("alu_ret1", 4'b0000, 1'b0, 1'b0, 3'b110);
        ex_cnt("alu_ret1", 0, 0, 1);
        sample();
        @(negedge clk);
        ex_out("alu_ret2", 4'b0000, 1'b0, 1'b0, 3'b100);
        sample();

        // Load-use: lw r8 (lat 2) ; add r9<-r8,r8 stalls one cycle then bypasses from slot 2
        @(negedge clk);
        drive(1, 5'd9, 5'd0, 2'b01, 5'd8, 1, 2'd2, 0, 0);
        ex_out("lw8", 4'b0000, 1'b0, 1'b0, 3'b000);
        ex_cnt("lw8", 0, 0, 3);
        sample();
        @(negedge clk);
        drive(1, 5'd8, 5'd8, 2'b11, 5'd9, 1, 2'd1, 0, 0);
        ex_out("lu_stall", 4'b0000, 1'b1, 1'b0, 3'b001);
        ex_cnt("lu_stall", 0, 0, 3);
        sample();
        @(negedge clk);
        ex_out("lu_fwd", 4'b1010, 1'b0, 1'b0, 3'b010);
        ex_cnt("lu_fwd", 1, 0, 3);
        sample();
        @(negedge clk);
        idle();
        ex_out("lu_after", 4'b0000, 1'b0, 1'b0, 3'b101);
        ex_cnt("lu_after", 1, 0, 3);
        sample();

        // Register zero and unused sources never stall or bypass
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd0, 1, 2'd2, 0, 0);
        ex_out("lw_r0", 4'b0000, 1'b0, 1'b0, 3'b010);
        sample();
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b11, 5'd10, 1, 2'd2, 0, 0);
        ex_out("read_r0", 4'b0000, 1'b0, 1'b0, 3'b101);
        sample();
        @(negedge clk);
        drive(1, 5'd10, 5'd10, 2'b00, 5'd11, 0, 2'd1, 0, 0);
        ex_out("unused_src", 4'b0000, 1'b0, 1'b0, 3'b011);
        sample();
        repeat (3) begin
            @(negedge clk);
            idle();
        end

        // Redirect from slot 2: younger slot 1 and the decode entry are killed
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 2'd1, 0, 0);
        ex_out("br_a", 4'b0000, 1'b0, 1'b0, 3'b000);
        ex_cnt("br_a", 1, 0, 8);
        sample();
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 2'd1, 0, 0);
        ex_out("br_b", 4'b0000, 1'b0, 1'b0, 3'b001);
        sample();
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 2'd1, 0, 1);
        ex_out("redir", 4'b0000, 1'b0, 1'b1, 3'b011);
        ex_cnt("redir", 1, 0, 8);
        sample();
        @(negedge clk);
        drive(1, 5'd31, 5'd0, 2'b01, 5'd12, 1, 2'd1, 0, 0);
        ex_out("post_redir", 4'b0011, 1'b0, 1'b0, 3'b100);
        ex_cnt("post_redir", 1, 1, 8);
        sample();

        // ext_stall for 4 cycles with a pending load-use and a held redirect
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd13, 1, 2'd2, 0, 0);
        ex_out("lw13", 4'b0000, 1'b0, 1'b0, 3'b001);
        ex_cnt("lw13", 1, 1, 9);
        sample();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1, 5'd13, 5'd0, 2'b01, 5'd14, 1, 2'd1, 1, 1);
            ex_out("ext_hold", 4'b0000, 1'b1, 1'b0, 3'b011);
            ex_cnt("ext_hold", 32'(1 + c), 1, 9);
            sample();
        end
        @(negedge clk);
        drive(1, 5'd13, 5'd0, 2'b01, 5'd14, 1, 2'd1, 0, 1);
        ex_out("ext_free", 4'b0000, 1'b0, 1'b1, 3'b011);
        ex_cnt("ext_free", 5, 1, 9);
        sample();
        @(negedge clk);
        idle();
        ex_out("ext_after", 4'b0000, 1'b0, 1'b0, 3'b100);
        ex_cnt("ext_after", 5, 2, 9);
        sample();

        // Reset mid-stream with a full pipe and nonzero counters
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd20, 1, 2'd1, 0, 0);
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd21, 1, 2'd1, 0, 0);
        @(negedge clk);
        drive(1, 5'd0, 5'd0, 2'b00, 5'd22, 1, 2'd1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 5'd22, 5'd0, 2'b01, 5'd0, 0, 2'd1, 1, 1);
        ex_out("pre_reset", 4'b0001, 1'b1, 1'b0, 3'b111);
        ex_cnt("pre_reset", 5, 2, 10);
        sample();
        @(negedge clk);
        reset = 1'b0;
        drive(1, 5'd22, 5'd0, 2'b01, 5'd0, 0, 2'd1, 0, 0);
        ex_out("mid_reset", 4'b0000, 1'b0, 1'b0, 3'b000);
        ex_cnt("mid_reset", 0, 0, 0);
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
